posit_to_fp32_pipe: RTL and testbench

- Parametrised, pipelined posit<N,ES> to IEEE-754 binary32 converter.
- Successor to the fixed posit<16,1> combinational decoder. Adds:
  - generic N/ES
  - zero and NaR handling
  - round-to-nearest-even when the posit fraction is wider than 23 bits
  - valid/ready streaming with backpressure
- Sits between the PPU posit register file / load path and fp32 consumers (debug port, host readback).

---
 rtl/posit_pkg.sv | 28 ++
 rtl/posit_to_fp32_pipe_if.sv | 31 +++
 rtl/posit_lzc.sv | 27 ++
 rtl/posit_to_fp32_pipe.sv | 147 ++++++++++++++
 tb/tb_posit_to_fp32_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants, S1 payload type and width helper for the posit converter
//
// Purpose : common definitions imported by posit_lzc and posit_to_fp32_pipe.
// Contents: fp32 bias / quiet-NaN / mantissa width, 29-bit fraction datapath
//           width, S1 payload struct, regime run-count width function.
package posit_pkg;

    localparam int          FP32_BIAS   = 127;
    localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
    localparam int          FP32_MANT_W = 23;
    // Widest posit fraction (N=32, ES=0) is 29 bits; narrower fractions are
    // left-aligned in this field and zero-padded.
    localparam int          FRAC_W      = 29;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              nar;
        logic [7:0]        scale;   // two's complement (k << ES) + e
        logic [FRAC_W-1:0] frac;    // left-aligned, zero-padded
    } s1_payload_t;

    // Bits needed to hold a run length of 0..width.
    function automatic int regime_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/posit_to_fp32_pipe_if.sv
// rtl/posit_to_fp32_pipe_if.sv - stream interface bundle for the posit to fp32 converter
//
// Purpose : groups input and output valid/ready streams.
// Ports   : in_valid/in_ready/in_posit[N-1:0]   posit input stream
//           out_valid/out_ready/out_fp32[31:0]  fp32 result stream
//           out_nar/out_inexact                 status, only with POSIT_FP_STATUS_EN
// Modports: master (producer/consumer side), slave (converter side).
interface posit_to_fp32_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_posit;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_fp32;
`ifdef POSIT_FP_STATUS_EN
    logic         out_nar;
    logic         out_inexact;

    modport master (output in_valid, in_posit, out_ready,
                    input  in_ready, out_valid, out_fp32, out_nar, out_inexact);
    modport slave  (input  in_valid, in_posit, out_ready,
                    output in_ready, out_valid, out_fp32, out_nar, out_inexact);
`else
    modport master (output in_valid, in_posit, out_ready,
                    input  in_ready, out_valid, out_fp32);
    modport slave  (input  in_valid, in_posit, out_ready,
                    output in_ready, out_valid, out_fp32);
`endif
endinterface

// File: rtl/posit_lzc.sv
// rtl/posit_lzc.sv - leading run-length counter used for posit regime decoding
//
// Purpose : counts how many leading bits equal the MSB (zeros or ones).
// Ports   : bits_i[W-1:0]  input vector
//           run_o[CW-1:0]  run length, 1..W (W when all bits are equal)
module posit_lzc import posit_pkg::*; #(
    parameter int W  = 15,
    parameter int CW = regime_cnt_w(W)
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] run_o
);

    logic done;

    always_comb begin
        run_o = CW'(W);
        done  = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!done && (bits_i[i] != bits_i[W-1])) begin
                run_o = CW'(W - 1 - i);
                done  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_to_fp32_pipe.sv
// rtl/posit_to_fp32_pipe.sv - two-stage pipelined posit<N,ES> to binary32 converter
//
// Purpose : S1 decodes sign/regime/exponent/fraction, S2 assembles the fp32
//           word with round-to-nearest-even. Full valid/ready backpressure.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    posit_to_fp32_pipe_if.slave (in_* / out_* streams)
// Options : POSIT_FP_STATUS_EN adds registered out_nar and out_inexact.
module posit_to_fp32_pipe import posit_pkg::*; #(
    parameter int N  = 16,
    parameter int ES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    posit_to_fp32_pipe_if.slave  bus
);

    localparam int CW = regime_cnt_w(N - 1);

    // Every posit must land on a normal fp32 and the scale must fit 8 bits.
    if (N < 8 || N > 32 || ES < 0 || ES > 3 || ((N - 2) << ES) > 126) begin : g_bad_cfg
        $error("posit_to_fp32_pipe: illegal N=%0d ES=%0d", N, ES);
    end

    logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    s1_payload_t s1_q, s1_d;
    logic [31:0] fp_q, fp_d;
    logic        s1_load, s2_load;

    assign s2_load       = !s2_valid_q || bus.out_ready;
    assign s1_load       = !s1_valid_q || s2_load;
    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_fp32  = fp_q;

    // ---------------- S1 decode ----------------
    logic [N-2:0]      body, shifted;
    logic [CW-1:0]     run;
    logic [7:0]        shamt, k, e_val, scale;
    logic [FRAC_W-1:0] frac;
    logic              is_zero, is_nar, unused_low;

    // Low N-1 bits of the two's complement magnitude; the top bit only matters for NaR.
    assign body = bus.in_posit[N-1] ? -bus.in_posit[N-2:0] : bus.in_posit[N-2:0];

    posit_lzc #(.W(N - 1)) u_lzc (
        .bits_i (body),
        .run_o  (run)
    );

    // Drop regime run plus terminator; exponent bits pushed off the end read as 0.
    assign shamt      = 8'(run) + 8'd1;
    assign shifted    = body << shamt;
    assign unused_low = ^shifted[1:0];
    assign k          = body[N-2] ? (8'(run) - 8'd1) : (8'd0 - 8'(run));

    always_comb begin
        e_val = 8'd0;
        for (int i = 0; i < ES; i++) begin
            e_val = {e_val[6:0], shifted[N-2-i]};
        end
    end

    assign scale   = (k << ES) + e_val;
    assign frac    = FRAC_W'(shifted[N-2-ES:2]) << (FRAC_W + 3 - N + ES);
    assign is_zero = (bus.in_posit == '0);
    assign is_nar  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sign  = bus.in_posit[N-1];
                s1_d.zero  = is_zero;
                s1_d.nar   = is_nar;
                s1_d.scale = scale;
                s1_d.frac  = frac;
            end
        end
    end

    // ---------------- S2 assemble ----------------
    logic [FP32_MANT_W-1:0] mant;
    logic                   guard, sticky, rnd;
    logic [31:0]            arith;

    assign mant   = s1_q.frac[FRAC_W-1 -: FP32_MANT_W];
    assign guard  = s1_q.frac[FRAC_W-FP32_MANT_W-1];
    assign sticky = |s1_q.frac[FRAC_W-FP32_MANT_W-2:0];
    assign rnd    = guard && (sticky || mant[0]);
    // Mantissa carry-out ripples straight into the exponent field.
    assign arith  = {s1_q.sign, s1_q.scale + 8'(FP32_BIAS), mant} + {31'd0, rnd};

    always_comb begin
        s2_valid_d = s2_valid_q;
        fp_d       = fp_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                fp_d = s1_q.nar ? FP32_QNAN : (s1_q.zero ? 32'h0 : arith);
            end
        end
    end

`ifdef POSIT_FP_STATUS_EN
    logic nar_q, nar_d, inexact_q, inexact_d;

    always_comb begin
        nar_d     = nar_q;
        inexact_d = inexact_q;
        if (s2_load && s1_valid_q) begin
            nar_d     = s1_q.nar;
            inexact_d = !s1_q.nar && !s1_q.zero && (guard || sticky);
        end
    end

    assign bus.out_nar     = nar_q;
    assign bus.out_inexact = inexact_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nar_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            nar_q     <= nar_d;
            inexact_q <= inexact_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            fp_q       <= 32'h0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            fp_q       <= fp_d;
        end
    end

endmodule

// File: tb/tb_posit_to_fp32_pipe.sv
// tb/tb_posit_to_fp32_pipe.sv - self-checking bench for posit_to_fp32_pipe (three N/ES configurations)
module tb_posit_to_fp32_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cfg_n [3] = '{16, 32, 32};
    int cfg_es[3] = '{1, 0, 2};

    logic        vld[3], rdy[3], ir[3], ov[3];
    logic [31:0] pos[3], of[3];
`ifdef POSIT_FP_STATUS_EN
    logic        onar[3], oinx[3];
`endif
    logic [32:0] sbq[3][$];

    posit_to_fp32_pipe_if #(.N(16)) b0();
    posit_to_fp32_pipe_if #(.N(32)) b1();
    posit_to_fp32_pipe_if #(.N(32)) b2();

    posit_to_fp32_pipe #(.N(16), .ES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    posit_to_fp32_pipe #(.N(32), .ES(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    posit_to_fp32_pipe #(.N(32), .ES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b0.in_valid = vld[0]; assign b0.in_posit = pos[0][15:0]; assign b0.out_ready = rdy[0];
    assign b1.in_valid = vld[1]; assign b1.in_posit = pos[1];       assign b1.out_ready = rdy[1];
    assign b2.in_valid = vld[2]; assign b2.in_posit = pos[2];       assign b2.out_ready = rdy[2];
    assign ir[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign of[0] = b0.out_fp32;
    assign ir[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign of[1] = b1.out_fp32;
    assign ir[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign of[2] = b2.out_fp32;
`ifdef POSIT_FP_STATUS_EN
    assign onar[0] = b0.out_nar; assign oinx[0] = b0.out_inexact;
    assign onar[1] = b1.out_nar; assign oinx[1] = b1.out_inexact;
    assign onar[2] = b2.out_nar; assign oinx[2] = b2.out_inexact;
`endif

    // Reference: decode the posit bit by bit into (sign, scale, fraction value),
    // then round the fraction to 23 bits with integer arithmetic. Returns {inexact, fp32}.
    function automatic logic [32:0] ref_fp(input int n, input int es, input logic [31:0] p_in);
        logic [31:0] mask, p, a;
        logic        sgn, r, inex;
        int          i, run, k, e, fbits, scale, sh;
        longint      fval, q, rem, half;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        p    = p_in & mask;
        if (p == 32'd0) return 33'h0;
        if (p == (32'd1 << (n - 1))) return {1'b0, 32'h7FC0_0000};
        sgn = p[n-1];
        a   = sgn ? ((~p + 32'd1) & mask) : p;
        i   = n - 2;
        r   = a[i];
        run = 0;
        while (i >= 0 && a[i] == r) begin
            run++;
            i--;
        end
        k = r ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        fbits = (i >= 0) ? i + 1 : 0;
        fval  = longint'(a) & ((64'sd1 <<< fbits) - 1);
        scale = k * (1 << es) + e;
        inex  = 1'b0;
        if (fbits <= 23) begin
            q = fval <<< (23 - fbits);
        end else begin
            sh   = fbits - 23;
            q    = fval >>> sh;
            rem  = fval - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 23)) begin
                q = 0;
                scale = scale + 1;
            end
        end
        return {inex, sgn, 8'(scale + 127), 23'(q)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample just after the falling edge, score transfers, advance to next falling edge.
    task automatic tick();
        logic [32:0] e;
        #1;
        for (int d = 0; d < 3; d++) begin
            if (ov[d] && rdy[d]) begin
                tests++;
                assert (sbq[d].size() != 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected[%0d]: observed output %h expected none", d, of[d]);
                end
                if (sbq[d].size() != 0) begin
                    e = sbq[d].pop_front();
                    check($sformatf("sb_data[%0d]", d), of[d], e[31:0]);
`ifdef POSIT_FP_STATUS_EN
                    check($sformatf("sb_inexact[%0d]", d), {31'd0, oinx[d]}, {31'd0, e[32]});
`endif
                end
            end
            if (vld[d] && ir[d]) sbq[d].push_back(ref_fp(cfg_n[d], cfg_es[d], pos[d]));
        end
        @(negedge clk);
    endtask

    // Single item: accepted on the first edge, visible after the second.
    task automatic single(input int d, input logic [31:0] p, input logic [31:0] exp,
                          input logic exp_inx, input string tag);
        vld[d] = 1'b1; pos[d] = p; rdy[d] = 1'b1;
        tick();
        vld[d] = 1'b0;
        tick();
        check({tag, "_valid"}, {31'd0, ov[d]}, 32'd1);
        check(tag, of[d], exp);
`ifdef POSIT_FP_STATUS_EN
        check({tag, "_nar"}, {31'd0, onar[d]}, {31'd0, exp == 32'h7FC0_0000});
        check({tag, "_inexact"}, {31'd0, oinx[d]}, {31'd0, exp_inx});
`else
        if (exp_inx) begin end
`endif
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0; rdy[d] = 1'b1; pos[d] = 32'h0;
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid[%0d]", d), {31'd0, ov[d]}, 32'd0);
            check($sformatf("rst_data[%0d]", d), of[d], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("rst_ready[%0d]", d), {31'd0, ir[d]}, 32'd1);

        // Back-to-back stream, N=16 ES=1
        vld[0] = 1'b1; pos[0] = 32'h4000; tick();
        check("lat_not_early", {31'd0, ov[0]}, 32'd0);
        pos[0] = 32'hC000; tick();
        check("stream0", of[0], 32'h3F80_0000);
        check("stream0_valid", {31'd0, ov[0]}, 32'd1);
        pos[0] = 32'h4800; tick();
        check("stream1", of[0], 32'hBF80_0000);
        pos[0] = 32'h5000; tick();
        check("stream2", of[0], 32'h3FC0_0000);
        vld[0] = 1'b0; tick();
        check("stream3", of[0], 32'h4000_0000);
        tick();
        check("stream_empty", {31'd0, ov[0]}, 32'd0);

        // Specials and extremes, N=16 ES=1
        single(0, 32'h0000, 32'h0000_0000, 1'b0, "zero");
        single(0, 32'h8000, 32'h7FC0_0000, 1'b0, "nar");
        single(0, 32'h7FFF, 32'h4D80_0000, 1'b0, "maxpos");
        single(0, 32'h0001, 32'h3180_0000, 1'b0, "minpos");

        // Rounding, N=32 ES=0
        single(1, 32'h4000_0001, 32'h3F80_0000, 1'b1, "rne_sticky");
        single(1, 32'h4000_0020, 32'h3F80_0000, 1'b1, "rne_tie_even");
        single(1, 32'h4000_0060, 32'h3F80_0002, 1'b1, "rne_tie_odd");

        // Backpressure, N=16 ES=1
        rdy[0] = 1'b0; vld[0] = 1'b1; pos[0] = 32'h4000; tick();
        pos[0] = 32'h5000; tick();
        pos[0] = 32'h4800;
        check("bp_ready_low", {31'd0, ir[0]}, 32'd0);
        check("bp_head", of[0], 32'h3F80_0000);
        tick(); tick();
        check("bp_hold", of[0], 32'h3F80_0000);
        check("bp_hold_valid", {31'd0, ov[0]}, 32'd1);
        rdy[0] = 1'b1; tick();
        vld[0] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("bp_drained", sbq[0].size(), 32'd0);

        // Reset with two items in flight
        for (int d = 0; d < 3; d++) rdy[d] = 1'b0;
        vld[0] = 1'b1; vld[1] = 1'b1; pos[0] = 32'h4000; pos[1] = 32'h4000_0000; tick();
        pos[0] = 32'h5000; pos[1] = 32'h5000_0000; tick();
        vld[0] = 1'b0; vld[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, ov[0]}, 32'd0);
        check("arst_data", of[0], 32'h0);
        check("arst_data1", of[1], 32'h0);
        for (int d = 0; d < 3; d++) sbq[d].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) rdy[d] = 1'b1;
        #1 check("arst_ready", {31'd0, ir[0]}, 32'd1);
        for (int c = 0; c < 4; c++) tick();
        check("arst_no_stale", {31'd0, ov[0]}, 32'd0);

        // Random sweep on all three configurations
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d] = ($urandom_range(0, 3) != 0);
                rdy[d] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 15))
                    0:       pos[d] = 32'h0;
                    1:       pos[d] = 32'd1 << (cfg_n[d] - 1);
                    default: pos[d] = $urandom;
                endcase
                if (cfg_n[d] == 16) pos[d] = pos[d] & 32'hFFFF;
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0; rdy[d] = 1'b1;
        end
        for (int c = 0; c < 5; c++) tick();
        for (int d = 0; d < 3; d++) check($sformatf("rand_drained[%0d]", d), sbq[d].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
